// File: rtl/genaxis_regs_pkg.sv
// Register map constants and helpers shared by the AXI-Stream generator control block.
package genaxis_regs_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_STRB_W = REG_W / 8;
    localparam int unsigned MAP_ADDR_W = 8;

    localparam logic [31:0] ID_VALUE    = 32'h4741_5853;
    localparam logic [15:0] PKT_LEN_RST = 16'd64;

    localparam logic [MAP_ADDR_W-1:0] OFF_ID        = 8'h00;
    localparam logic [MAP_ADDR_W-1:0] OFF_CTRL      = 8'h04;
    localparam logic [MAP_ADDR_W-1:0] OFF_STATUS    = 8'h08;
    localparam logic [MAP_ADDR_W-1:0] OFF_PKT_LEN   = 8'h0C;
    localparam logic [MAP_ADDR_W-1:0] OFF_PKT_COUNT = 8'h10;
    localparam logic [MAP_ADDR_W-1:0] OFF_GAP       = 8'h14;
    localparam logic [MAP_ADDR_W-1:0] OFF_SEED      = 8'h18;
    localparam logic [MAP_ADDR_W-1:0] OFF_TX_PKTS   = 8'h1C;
    localparam logic [MAP_ADDR_W-1:0] OFF_IRQ_EN    = 8'h20;

    localparam int unsigned CTRL_ENABLE   = 0;
    localparam int unsigned CTRL_START    = 1;
    localparam int unsigned CTRL_SOFT_RST = 2;
    localparam int unsigned CTRL_LOOP     = 3;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_ERROR = 2;

    // Byte-lane merge of write data into a register under the write strobes.
    function automatic logic [REG_W-1:0] merge_bytes(
        input logic [REG_W-1:0]      cur,
        input logic [REG_W-1:0]      wdata,
        input logic [REG_STRB_W-1:0] strb
    );
        logic [REG_W-1:0] res;
        res = cur;
        for (int i = 0; i < int'(REG_STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/genaxis_sat_cnt.sv
// Saturating event counter with a synchronous clear that takes priority over increment.
module genaxis_sat_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/genaxis_ctrl_regs.sv
// Control/status register file for the AXI-Stream generator behind the AXI-Lite strobe bridge.
module genaxis_ctrl_regs
    import genaxis_regs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    parameter logic [31:0] ID_VALUE    = genaxis_regs_pkg::ID_VALUE,
    parameter logic [15:0] PKT_LEN_RST = genaxis_regs_pkg::PKT_LEN_RST
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb,
    input  logic                  reg_wr_en,
    output logic                  reg_wr_wait,
    output logic                  reg_wr_ack,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                  reg_rd_en,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_wait,
    output logic                  reg_rd_ack,

    output logic                  cfg_enable,
    output logic                  cfg_loop,
    output logic [15:0]           cfg_pkt_len,
    output logic [31:0]           cfg_pkt_count,
    output logic [15:0]           cfg_gap,
    output logic [31:0]           cfg_seed,
    output logic                  cmd_start,
    output logic                  cmd_soft_rst,

    input  logic                  gen_busy,
    input  logic                  gen_pkt_done,
    input  logic                  gen_done,
    input  logic                  gen_error,
    output logic                  irq
);

    localparam int unsigned OFF_W = MAP_ADDR_W;

    logic [OFF_W-1:0]      wr_off_c;
    logic [OFF_W-1:0]      rd_off_c;
    logic                  wr_fire_c;
    logic                  rd_fire_c;
    logic                  ctrl_wr_c;
    logic                  status_wr_c;
    logic                  soft_rst_c;
    logic                  tx_clr_c;
    logic [DATA_WIDTH-1:0] rd_mux_c;

    logic        done;
    logic        error;
    logic [1:0]  irq_en;
    logic [31:0] tx_pkts;
    logic        unused_addr_bits;

    assign reg_wr_wait = 1'b0;
    assign reg_rd_wait = 1'b0;

    // The bridge holds en through the ack cycle, so that cycle never re-executes.
    assign wr_fire_c = reg_wr_en && !reg_wr_ack;
    assign rd_fire_c = reg_rd_en && !reg_rd_ack;
    assign wr_off_c  = {reg_wr_addr[OFF_W-1:2], 2'b00};
    assign rd_off_c  = {reg_rd_addr[OFF_W-1:2], 2'b00};

    assign ctrl_wr_c   = wr_fire_c && (wr_off_c == OFF_CTRL) && reg_wr_strb[0];
    assign status_wr_c = wr_fire_c && (wr_off_c == OFF_STATUS) && reg_wr_strb[0];
    assign soft_rst_c  = ctrl_wr_c && reg_wr_data[CTRL_SOFT_RST];
    assign tx_clr_c    = soft_rst_c || (wr_fire_c && (wr_off_c == OFF_TX_PKTS));

    assign unused_addr_bits = &{1'b0, reg_wr_addr[ADDR_WIDTH-1:OFF_W], reg_wr_addr[1:0],
                                reg_rd_addr[ADDR_WIDTH-1:OFF_W], reg_rd_addr[1:0]};

    genaxis_sat_cnt #(
        .WIDTH (32)
    ) u_tx_pkts (
        .clk   (clk),
        .rst   (rst),
        .clr   (tx_clr_c),
        .inc   (gen_pkt_done),
        .count (tx_pkts)
    );

    // Read mux over current (pre-write) state; unused bits stay 0.
    always_comb begin
        rd_mux_c = '0;
        case (rd_off_c)
            OFF_ID:        rd_mux_c = ID_VALUE;
            OFF_CTRL: begin
                rd_mux_c[CTRL_ENABLE] = cfg_enable;
                rd_mux_c[CTRL_LOOP]   = cfg_loop;
            end
            OFF_STATUS: begin
                rd_mux_c[STAT_BUSY]  = gen_busy;
                rd_mux_c[STAT_DONE]  = done;
                rd_mux_c[STAT_ERROR] = error;
            end
            OFF_PKT_LEN:   rd_mux_c[15:0] = cfg_pkt_len;
            OFF_PKT_COUNT: rd_mux_c = cfg_pkt_count;
            OFF_GAP:       rd_mux_c[15:0] = cfg_gap;
            OFF_SEED:      rd_mux_c = cfg_seed;
            OFF_TX_PKTS:   rd_mux_c = tx_pkts;
            OFF_IRQ_EN:    rd_mux_c[STAT_ERROR:STAT_DONE] = irq_en;
            default:       ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_ack    <= 1'b0;
            reg_rd_ack    <= 1'b0;
            reg_rd_data   <= '0;
            cmd_start     <= 1'b0;
            cmd_soft_rst  <= 1'b0;
            cfg_enable    <= 1'b0;
            cfg_loop      <= 1'b0;
            cfg_pkt_len   <= PKT_LEN_RST;
            cfg_pkt_count <= '0;
            cfg_gap       <= '0;
            cfg_seed      <= '0;
            irq_en        <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            irq           <= 1'b0;
        end else begin
            reg_wr_ack   <= wr_fire_c;
            reg_rd_ack   <= rd_fire_c;
            cmd_start    <= ctrl_wr_c && reg_wr_data[CTRL_ENABLE] && reg_wr_data[CTRL_START];
            cmd_soft_rst <= soft_rst_c;

            if (rd_fire_c) reg_rd_data <= rd_mux_c;

            // A new event wins over a coincident W1C or soft reset.
            done  <= gen_done  || (done  && !(status_wr_c && reg_wr_data[STAT_DONE])  && !soft_rst_c);
            error <= gen_error || (error && !(status_wr_c && reg_wr_data[STAT_ERROR]) && !soft_rst_c);
            irq   <= |({error, done} & irq_en);

            if (ctrl_wr_c) begin
                cfg_enable <= reg_wr_data[CTRL_ENABLE];
                cfg_loop   <= reg_wr_data[CTRL_LOOP];
            end

            if (wr_fire_c) begin
                case (wr_off_c)
                    OFF_PKT_LEN:   cfg_pkt_len   <= 16'(merge_bytes({16'h0, cfg_pkt_len}, reg_wr_data, reg_wr_strb));
                    OFF_PKT_COUNT: cfg_pkt_count <= merge_bytes(cfg_pkt_count, reg_wr_data, reg_wr_strb);
                    OFF_GAP:       cfg_gap       <= 16'(merge_bytes({16'h0, cfg_gap}, reg_wr_data, reg_wr_strb));
                    OFF_SEED:      cfg_seed      <= merge_bytes(cfg_seed, reg_wr_data, reg_wr_strb);
                    OFF_IRQ_EN: begin
                        if (reg_wr_strb[0]) irq_en <= reg_wr_data[STAT_ERROR:STAT_DONE];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
